booth_mult_16bit_seq: RTL
=========================

# booth_mult_16bit_seq

Sequential signed 16x16 -> 32-bit multiplier using radix-2 Booth recoding, one Booth step per clock. It has no adder of its own. Every iteration drives the operands and the add/sub control of the external combinational 16-bit adder/subtractor (`adder_16bit_b`), then registers that adder's SUM in the same cycle. Operands arrive and the product leaves over valid/ready handshakes.

## Interface
Parameters:
- none (width fixed at 16-bit operands, 32-bit product)

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept operands; equals (state == IDLE).
- `in_mcand` in 16: multiplicand M, two's complement.
- `in_mplier` in 16: multiplier Q, two's complement.
- `out_valid` out 1: product valid; high only in DONE.
- `out_ready` in 1: consumer accepts product.
- `out_prod` out 32: signed product M*Q, registered.
- `add_a` out 16: to adder A; equals register HI.
- `add_b` out 16: to adder B; equals register MREG.
- `add_ctrl` out 1: to adder Add_ctrl (1 = subtract A-B, 0 = add A+B).
- `add_sum` in 16: from adder SUM. Adder is combinational, so the result is valid in the same cycle.

The adder's C_out and O outputs are not connected.

## Operation
Registers:
- `HI[15:0]`, `LO[15:0]`: partial product.
- `QM1`: Booth guard bit.
- `MREG[15:0]`: latched multiplicand.
- `CNT[3:0]`: iteration counter.
- `STATE`: one of IDLE, RUN, DONE.
- `out_prod`.

Reset, applied while `rst_n` = 0 at a clock edge:
- STATE = IDLE.
- HI, LO, QM1, MREG, CNT = 0.
- `out_prod` = 0.
- Resulting outputs: `out_valid` = 0, `in_ready` = 1 (once STATE = IDLE), `add_a` = `add_b` = 0, `add_ctrl` = 0.

IDLE:
- On `in_valid` && `in_ready`: MREG <= `in_mcand`; HI <= 0; LO <= `in_mplier`; QM1 <= 0; CNT <= 0; go to RUN.

RUN, one Booth step per cycle. The decode is {LO[0], QM1}:
- 01: `add_ctrl` = 0. New high half N = `add_sum`.
- 10: `add_ctrl` = 1. New high half N = `add_sum`.
- 00 or 11: `add_ctrl` = 0, but the adder result is ignored. N = HI.

Overflow correction:
- V = signed overflow of the active operation, computed locally from HI[15], MREG[15] and `add_sum`[15].
  - Add: V = (HI[15] == MREG[15]) && (sum[15] != HI[15]).
  - Subtract: V = (HI[15] != MREG[15]) && (sum[15] != HI[15]).
- V is forced to 0 for decodes 00 and 11.
- True sign S = N[15] ^ V.

Arithmetic shift right of the 33-bit {S, N, LO} into {HI, LO, QM1}:
- HI <= {S, N[15:1]}
- LO <= {N[0], LO[15:1]}
- QM1 <= LO[0]

Counter and exit:
- CNT increments each RUN cycle.
- On the step where CNT == 15: `out_prod` <= {HI_next, LO_next}; go to DONE.

DONE:
- `out_valid` = 1; `out_prod` is held stable.
- On `out_ready`: go to IDLE.
- `in_ready` is 0 in this state. There is no bypass from DONE straight to RUN.

## Timing
- Accept edge is T0. RUN occupies cycles T0+1 through T0+16. `out_valid` rises after edge T0+16.
- Latency from accept to `out_valid` is 16 cycles. Minimum issue interval is 18 cycles, with `out_ready` tied high.
- `add_a`, `add_b`, `add_ctrl` are combinational from the registers and the decode. They are stable for the whole cycle, and `add_sum` is captured at the end of that same cycle.
- Outside RUN, `add_ctrl` = 0 and `add_a`/`add_b` reflect register contents; the adder output is ignored.
- Back-pressure: while `out_ready` = 0, DONE holds indefinitely and `out_prod` does not change.
- `in_valid` outside IDLE is ignored; operands are not queued.
- Reset mid-RUN or mid-DONE: the next cycle is IDLE with all registers zero. The in-flight result is discarded and no `out_valid` pulse occurs.
- Overflow case: M = 0x8000 with a subtract step produces V = 1. The S correction keeps the result exact, including -32768 * -32768.

## Test plan
- 3 x 5: accept at T0 -> `out_valid` at T0+17 with `out_prod` = 0x0000000F; `in_ready` = 0 during RUN and DONE.
- -7 (0xFFF9) x 6 -> 0xFFFFFFD6; 0x7FFF x 0x8000 -> 0xC0008000; 0x0000 x 0x1234 -> 0x00000000.
- 0x8000 x 0x8000 -> 0x40000000. Check that V = 1 on the subtract step and that `add_ctrl` pulses match the Booth decode of 0x8000 (a single subtract at step 15).
- Hold `out_ready` = 0 for 10 cycles after `out_valid` -> `out_prod` stable, `in_valid` ignored. Raise `out_ready` -> IDLE next cycle, `in_ready` = 1.
- Drive `rst_n` = 0 for one edge at CNT = 7 -> all outputs at reset values next cycle, no `out_valid`. A new 2 x -3 then returns 0xFFFFFFFA.
- Random signed pairs (1000+) compared against a 32-bit signed model, with random `in_valid`/`out_ready` gaps -> zero mismatches.

Source files
------------

// File: rtl/booth_mult_16bit_seq_if.sv
// rtl/booth_mult_16bit_seq_if.sv - operand/product handshake bundle for booth_mult_16bit_seq
interface booth_mult_16bit_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_mcand;
    logic [15:0] in_mplier;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_prod;

    modport master (
        output in_valid, in_mcand, in_mplier, out_ready,
        input  in_ready, out_valid, out_prod
    );

    modport slave (
        input  in_valid, in_mcand, in_mplier, out_ready,
        output in_ready, out_valid, out_prod
    );
endinterface

// File: rtl/booth_mult_16bit_seq.sv
// rtl/booth_mult_16bit_seq.sv - radix-2 Booth 16x16 signed multiplier, one step per clock
// Uses an external combinational adder; overflow-corrected sign keeps the 17th bit exact.
module booth_mult_16bit_seq (
    input  logic                         clk,
    input  logic                         rst_n,
    booth_mult_16bit_seq_if.slave        bus,
    output logic [15:0]                  add_a,
    output logic [15:0]                  add_b,
    output logic                         add_ctrl,
    input  logic [15:0]                  add_sum
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_hi;
    logic [15:0] r_lo;
    logic [15:0] r_mreg;
    logic        r_qm1;
    logic [3:0]  r_cnt;
    logic [31:0] r_prod;

    logic [15:0] w_n;
    logic [15:0] w_hi_next;
    logic [15:0] w_lo_next;
    logic        w_v;
    logic        w_s;
    logic        w_add_ctrl;
    logic        w_accept;
    logic        w_last;

    assign add_a         = r_hi;
    assign add_b         = r_mreg;
    assign add_ctrl      = w_add_ctrl;
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_prod  = r_prod;
    assign w_accept      = bus.in_valid && (r_state == IDLE);
    assign w_last        = (r_cnt == 4'd15);

    // Booth step: V recovers the lost 17th bit so the arithmetic shift keeps the true sign.
    always_comb begin
        w_add_ctrl = 1'b0;
        w_n        = r_hi;
        w_v        = 1'b0;
        if (r_state == RUN) begin
            case ({r_lo[0], r_qm1})
                2'b01: begin
                    w_n = add_sum;
                    w_v = (r_hi[15] == r_mreg[15]) && (add_sum[15] != r_hi[15]);
                end
                2'b10: begin
                    w_add_ctrl = 1'b1;
                    w_n        = add_sum;
                    w_v        = (r_hi[15] != r_mreg[15]) && (add_sum[15] != r_hi[15]);
                end
                default: ;
            endcase
        end
        w_s       = w_n[15] ^ w_v;
        w_hi_next = {w_s, w_n[15:1]};
        w_lo_next = {w_n[0], r_lo[15:1]};
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)      w_state_next = RUN;
            RUN:     if (w_last)        w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_hi    <= 16'd0;
            r_lo    <= 16'd0;
            r_mreg  <= 16'd0;
            r_qm1   <= 1'b0;
            r_cnt   <= 4'd0;
            r_prod  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mreg <= bus.in_mcand;
                        r_hi   <= 16'd0;
                        r_lo   <= bus.in_mplier;
                        r_qm1  <= 1'b0;
                        r_cnt  <= 4'd0;
                    end
                end
                RUN: begin
                    r_hi  <= w_hi_next;
                    r_lo  <= w_lo_next;
                    r_qm1 <= r_lo[0];
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) begin
                        r_prod <= {w_hi_next, w_lo_next};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
